// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// Package  : maze_pkg
// Brief    : Shared map geometry defaults, image indices, FSM and row types.
// Revision : 1.0 - initial release
// ============================================================================
package maze_pkg;

    localparam int MAP_W_DEF      = 20;
    localparam int MAP_H_DEF      = 15;
    localparam int NUM_LEVELS_DEF = 4;
    localparam int LEVEL_TITLE    = 0;
    localparam int END_IMAGE      = NUM_LEVELS_DEF;
    localparam int NUM_IMAGES     = END_IMAGE + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [MAP_W_DEF-1:0] row_t;

endpackage
`default_nettype wire

// File: rtl/maze_level_rom.sv
`default_nettype none
// ============================================================================
// Module   : maze_level_rom
// Brief    : Combinational level image ROM, (image, row) -> row of wall bits.
// Revision : 1.0 - initial release
// ============================================================================
module maze_level_rom
    import maze_pkg::*;
#(
    parameter int LVL_W = 3,
    parameter int YW    = 4
) (
    input  logic [LVL_W-1:0] i_img,
    input  logic [YW-1:0]    i_row,
    output row_t             o_row
);

    // Leftmost literal bit is column 0; image order: title, maze 1, maze 2, obstacle, END.
    localparam row_t C_ROM [0:NUM_IMAGES-1][0:MAP_H_DEF-1] = '{
        '{20'h00000, 20'h00000, 20'h00000,
          20'b10001_01110_11110_11110, 20'b11011_10001_00010_10000,
          20'b10101_11111_00100_11100, 20'b10001_10001_01000_10000,
          20'b10001_10001_11110_11110,
          20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000},
        '{20'b11111_11111_11111_11111, 20'b10000_00000_00000_00001,
          20'b10111_10011_11111_01101, 20'b10100_00010_00001_01001,
          20'b10101_11010_11101_01011, 20'b10001_00000_10001_00001,
          20'b11101_01111_10101_11101, 20'b10000_01000_00100_00001,
          20'b10111_11011_10111_11101, 20'b10100_00010_00000_00101,
          20'b10101_11110_11111_10101, 20'b10001_00000_00001_00001,
          20'b11111_01111_11101_11101, 20'b10000_00000_00000_00001,
          20'b11111_11111_11111_11111},
        '{20'b11111_11111_11111_11111, 20'b10000_00100_00000_00001,
          20'b10110_10101_11110_11101, 20'b10010_10001_00000_10001,
          20'b11010_11111_01111_10111, 20'b10000_00000_01000_00001,
          20'b10111_11101_11011_11101, 20'b10100_00001_00010_00101,
          20'b10101_11101_01110_10101, 20'b10001_00000_01000_10001,
          20'b11101_11011_11011_10111, 20'b10000_01000_00010_00001,
          20'b10111_01011_11010_11101, 20'b10000_00000_00000_00001,
          20'b11111_11111_11111_11111},
        '{20'b11111_11111_11111_11111, 20'b10000_00000_00000_00001,
          20'b10011_00000_00001_10001, 20'b10011_00011_00001_10001,
          20'b10000_00011_00000_00001, 20'b10000_00000_00000_00001,
          20'b10110_01100_00110_01101, 20'b10000_00000_00000_00001,
          20'b10000_11000_00011_00001, 20'b10000_11000_00011_00001,
          20'b10000_00000_00000_00001, 20'b10011_00001_10000_11001,
          20'b10000_00000_00000_00001, 20'b10000_00000_00000_00001,
          20'b11111_11111_11111_11111},
        '{20'h00000, 20'h00000, 20'h00000,
          20'b00111_01000_10011_10000, 20'b00100_01100_10010_01000,
          20'b00111_00010_00100_01110, 20'b00100_01001_10010_01000,
          20'b00111_01000_10011_10000,
          20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000}
    };

    always_comb begin
        o_row = '0;
        if ((32'(i_img) < 32'(NUM_IMAGES)) && (32'(i_row) < 32'(MAP_H_DEF))) begin
            o_row = C_ROM[i_img][i_row];
        end
    end

endmodule
`default_nettype wire

// File: rtl/maze_map_store.sv
`default_nettype none
// ============================================================================
// Module   : maze_map_store
// Brief    : Flop-based level wall bitmap with ROM loader, cell clear and two
//            registered lookup ports (collision and render).
// Revision : 1.0 - initial release
// ============================================================================
module maze_map_store
    import maze_pkg::*;
#(
    parameter int MAP_W      = MAP_W_DEF,
    parameter int MAP_H      = MAP_H_DEF,
    parameter int NUM_LEVELS = NUM_LEVELS_DEF,
    parameter int LVL_W      = 3,
    parameter int XW         = 5,
    parameter int YW         = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load_req,
    input  logic [LVL_W-1:0] load_level,
    input  logic             end_screen,
    output logic             busy,
    output logic             load_done,
    input  logic [XW-1:0]    col_x,
    input  logic [YW-1:0]    col_y,
    output logic             col_hit,
    input  logic [XW-1:0]    rd_x,
    input  logic [YW-1:0]    rd_y,
    output logic             rd_wall,
    input  logic             clr_en,
    input  logic [XW-1:0]    clr_x,
    input  logic [YW-1:0]    clr_y
);

    localparam logic [XW-1:0]    C_MAP_W    = XW'(MAP_W);
    localparam logic [XW-1:0]    C_LAST_COL = XW'(MAP_W - 1);
    localparam logic [YW-1:0]    C_MAP_H    = YW'(MAP_H);
    localparam logic [YW-1:0]    C_LAST_ROW = YW'(MAP_H - 1);
    localparam logic [LVL_W-1:0] C_END_IMG  = LVL_W'(NUM_LEVELS);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [YW-1:0]                 r_row;
    logic [LVL_W-1:0]              r_img;
    logic [LVL_W-1:0]              w_img_sel;
    logic [MAP_H-1:0][MAP_W-1:0]   r_map;
    logic [MAP_H-1:0][MAP_W-1:0]   w_map_nxt;
    logic [MAP_W-1:0]              w_rom_row;
    logic [MAP_W-1:0]              w_clr_mask;
    logic                          w_busy;
    logic                          w_load_done;
    logic                          w_load_wr;
    logic                          w_clr_ok;
    logic                          w_col_oob;
    logic                          w_rd_oob;
    logic                          r_col_hit;
    logic                          r_rd_wall;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_load_done = 1'b0;
        w_load_wr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_req) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_busy    = 1'b1;
                w_load_wr = 1'b1;
                if (r_row == C_LAST_ROW) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_load_done = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_img_sel = (end_screen || (load_level >= C_END_IMG)) ? C_END_IMG : load_level;

    // The counter parks on the last row so it never wraps past MAP_H-1.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_row <= '0;
            r_img <= '0;
        end else if ((r_state == IDLE) && load_req) begin
            r_row <= '0;
            r_img <= w_img_sel;
        end else if (w_load_wr && (r_row != C_LAST_ROW)) begin
            r_row <= r_row + YW'(1);
        end
    end

    maze_level_rom #(
        .LVL_W (LVL_W),
        .YW    (YW)
    ) u_rom (
        .i_img (r_img),
        .i_row (r_row),
        .o_row (w_rom_row)
    );

    assign w_clr_ok   = clr_en && !w_busy && (clr_x < C_MAP_W) && (clr_y < C_MAP_H);
    assign w_clr_mask = MAP_W'(1) << (C_LAST_COL - clr_x);

    for (genvar gr = 0; gr < MAP_H; gr++) begin : g_row
        assign w_map_nxt[gr] =
            (w_load_wr && (r_row == YW'(gr))) ? w_rom_row :
            (w_clr_ok  && (clr_y == YW'(gr))) ? (r_map[gr] & ~w_clr_mask) :
                                                r_map[gr];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_map <= '0;
        end else begin
            r_map <= w_map_nxt;
        end
    end

    assign w_col_oob = (col_x >= C_MAP_W) || (col_y >= C_MAP_H);
    assign w_rd_oob  = (rd_x >= C_MAP_W) || (rd_y >= C_MAP_H);

    // Lookups sample the pre-edge bitmap, so a same-cycle clear is not yet visible.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_col_hit <= 1'b1;
            r_rd_wall <= 1'b0;
        end else begin
            r_col_hit <= w_busy || w_col_oob || r_map[col_y][C_LAST_COL - col_x];
            r_rd_wall <= !w_rd_oob && r_map[rd_y][C_LAST_COL - rd_x];
        end
    end

    assign busy      = w_busy;
    assign load_done = w_load_done;
    assign col_hit   = r_col_hit;
    assign rd_wall   = r_rd_wall;

endmodule
`default_nettype wire

// File: doc/maze_map_store.md
Name: maze_map_store

Overview:
- Registered, parametrised successor to the per-level maze bitmap source.
- Holds the active level's wall bitmap (MAP_W x MAP_H cells, 1 = wall) in flops.
- Loads the bitmap row-by-row from a level ROM on request, and serves two registered lookup ports: player collision and renderer.
- Supports run-time cell clearing for breakable walls and opened doors.
- Sits between the game-state controller (level count, end state) and the movement and colour-mapper logic.

Parameters:
- MAP_W, 20, cells per row.
- MAP_H, 15, rows per map.
- NUM_LEVELS, 4, number of ROM images selectable by load_level; index 0 is the title banner.
- LVL_W, 3, width of load_level.
- XW, 5, width of column coordinates, ≥ clog2(MAP_W).
- YW, 4, width of row coordinates, ≥ clog2(MAP_H).

Ports:
- Clk, in, 1, system clock.
- Reset, in, 1, synchronous active-high reset.
- load_req, in, 1, single-cycle pulse; start loading a level.
- load_level, in, LVL_W, level index, sampled with load_req.
- end_screen, in, 1, sampled with load_req; 1 forces the END banner image.
- busy, out, 1, high while a load is in progress.
- load_done, out, 1, one-cycle pulse after the last row is written.
- col_x, in, XW, collision query column.
- col_y, in, YW, collision query row.
- col_hit, out, 1, registered wall bit at (col_x, col_y).
- rd_x, in, XW, render query column.
- rd_y, in, YW, render query row.
- rd_wall, out, 1, registered wall bit at (rd_x, rd_y).
- clr_en, in, 1, clear one cell this cycle.
- clr_x, in, XW, column of the cell to clear.
- clr_y, in, YW, row of the cell to clear.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous, active-high. Every register updates only on the rising edge of Clk.
- Bit mapping: row r occupies bitmap bits [r*MAP_W +: MAP_W]. Column c is bit MAP_W-1-c within that row, so ROM literals read left-to-right.
- Reset values:
  - bitmap all 0, state IDLE, row counter 0.
  - busy=0, load_done=0, col_hit=1, rd_wall=0.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - load_req=1 latches the image select, row counter to 0, next state LOAD.
  - Image select = END image if end_screen=1 or load_level ≥ NUM_LEVELS; otherwise load_level.
- LOAD:
  - Each cycle writes ROM row[row counter] into the bitmap and increments the counter.
  - After writing row MAP_H-1, next state DONE. A load therefore occupies exactly MAP_H cycles in LOAD.
  - busy=1 throughout LOAD and DONE.
  - load_req is ignored while in LOAD.
- DONE: load_done=1 for one cycle, then IDLE with busy=0. A load_req in DONE is ignored.
- Queries (1-cycle latency):
  - col_hit(t+1) and rd_wall(t+1) reflect the bitmap at edge t, using coordinates at edge t.
  - Out-of-range coordinates (x ≥ MAP_W or y ≥ MAP_H): col_hit=1, rd_wall=0.
  - While busy=1: col_hit=1, so the player cannot move during a load. rd_wall returns the partially loaded bitmap.
- Clear:
  - clr_en with in-range coordinates and busy=0 sets that cell to 0 at the next edge.
  - Out-of-range coordinates, or busy=1: no effect.
  - A clear and a query on the same cell in the same cycle: the query returns the pre-clear value. The query one cycle later returns 0.
- Reset mid-load: aborts to IDLE with the bitmap zeroed; no load_done pulse.
- Arithmetic: the row counter is YW bits, with no wrap past MAP_H-1. Coordinate compares are unsigned.

Decomposition:
- Package maze_pkg:
  - MAP_W and MAP_H defaults.
  - LEVEL_TITLE=0.
  - END image index = NUM_LEVELS.
  - enum state_t {IDLE, LOAD, DONE}.
  - Row type logic [MAP_W-1:0].
- Sub-module maze_level_rom:
  - Purely combinational (img, row) -> row bits.
  - Holds the title, maze 1, maze 2, obstacle maze and END banner images.
  - Any unused image index returns all-zero rows.

Test Plan:
- Load at level 1: Reset, then load_req with load_level=1 and end_screen=0 → busy high for 16 cycles (15 LOAD + 1 DONE), load_done pulses once at cycle 16. Query (0,0) → col_hit=1. Query (x=7,y=2) → 0.
- Out-of-range select: load_req with end_screen=1 and load_level=2 → END banner loaded; row 5 reads 20'b00111000100010001110. load_level=7 gives the same result.
- Collision bounds: query (20,3) and (3,15) → col_hit=1, rd_wall=0. Query (19,14) after level 2 → 1.
- Clear: clear (x=5,y=2) on level 1, with a same-cycle query → col_hit=1. Next query → 0. A clear issued while busy=1 leaves the cell unchanged.
- Ignored request: a second load_req issued during LOAD → ignored, exactly one load_done pulse.
- Reset mid-load: Reset asserted at LOAD cycle 7 → busy=0 next cycle, bitmap all 0, rd_wall=0 everywhere, no load_done pulse.
